// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator call scheduler.
package elevator_pkg;

  localparam int unsigned N_FLOORS_DEFAULT = 4;
  localparam int unsigned FLOOR_W_DEFAULT  = 2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2,
    BUSY   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/call_debounce.sv
// One call button: 2-flop synchroniser, stability counter, filtered level and
// a registered one-cycle pulse on each accepted rising edge.
module call_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Counter runs only while the synchronised input disagrees with the filtered
  // level; any return to agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches debounced floor calls and offers SCAN-ordered targets to the car FSM.
// Optional BUSY preemption by a closer in-path call: define SCHED_PREEMPT_EN.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS   = N_FLOORS_DEFAULT,
  parameter int unsigned FLOOR_W    = FLOOR_W_DEFAULT,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] btn_call,
  input  logic [FLOOR_W-1:0]  cur_floor,
  input  logic                at_floor,
  input  logic                target_ready,
  output logic                target_valid,
  output logic [FLOOR_W-1:0]  target_floor,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending
);

  sched_state_t        state, state_n;
  logic [FLOOR_W-1:0]  tgt_n;
  logic                valid_n;
  logic                dir_n;
  logic                dir_eff;
  logic [N_FLOORS-1:0] rise;
  logic [N_FLOORS-1:0] pend_clr;
  logic                has_above, has_below;
  logic [FLOOR_W-1:0]  above, below;

  for (genvar gi = 0; gi < int'(N_FLOORS); gi++) begin : g_deb
    call_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_call[gi]),
      .rise (rise[gi])
    );
  end

  always_comb begin
    pend_clr = '0;
    if (at_floor) pend_clr[cur_floor] = 1'b1;
  end

  // Clear dominates a simultaneous set on the same floor.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending | rise) & ~pend_clr;
  end

  // The end floors leave only one possible direction.
  always_comb begin
    dir_eff = dir_up;
    if (cur_floor == '0)                          dir_eff = DIR_UP;
    else if (cur_floor == FLOOR_W'(N_FLOORS - 1)) dir_eff = DIR_DOWN;
  end

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    has_above = 1'b0;
    above     = '0;
    has_below = 1'b0;
    below     = '0;
    for (int i = int'(N_FLOORS) - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
        has_above = 1'b1;
        above     = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < int'(N_FLOORS); i++) begin
      if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
        has_below = 1'b1;
        below     = FLOOR_W'(i);
      end
    end
  end

`ifdef SCHED_PREEMPT_EN
  logic               has_between;
  logic [FLOOR_W-1:0] between;

  // Pending floor closest to the car that lies on the way to the current target.
  always_comb begin
    has_between = 1'b0;
    between     = '0;
    if (target_floor > cur_floor) begin
      for (int i = int'(N_FLOORS) - 1; i >= 0; i--) begin
        if (pending[i] && (FLOOR_W'(i) > cur_floor) && (FLOOR_W'(i) < target_floor)) begin
          has_between = 1'b1;
          between     = FLOOR_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < int'(N_FLOORS); i++) begin
        if (pending[i] && (FLOOR_W'(i) < cur_floor) && (FLOOR_W'(i) > target_floor)) begin
          has_between = 1'b1;
          between     = FLOOR_W'(i);
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      target_floor <= '0;
      target_valid <= 1'b0;
      dir_up       <= DIR_UP;
    end else begin
      state        <= state_n;
      target_floor <= tgt_n;
      target_valid <= valid_n;
      dir_up       <= dir_n;
    end
  end

  // target_valid is registered, so it is raised on every transition into OFFER.
  always_comb begin
    state_n = state;
    tgt_n   = target_floor;
    valid_n = 1'b0;
    dir_n   = dir_eff;
    case (state)
      IDLE: begin
        if (pending != '0) state_n = SELECT;
      end
      SELECT: begin
        if (pending == '0) begin
          state_n = IDLE;
        end else begin
          state_n = OFFER;
          valid_n = 1'b1;
          if (pending[cur_floor]) begin
            tgt_n = cur_floor;
          end else if (dir_eff == DIR_UP) begin
            if (has_above) begin
              tgt_n = above;
            end else begin
              dir_n = DIR_DOWN;
              tgt_n = below;
            end
          end else begin
            if (has_below) begin
              tgt_n = below;
            end else begin
              dir_n = DIR_UP;
              tgt_n = above;
            end
          end
        end
      end
      OFFER: begin
        if (!pending[target_floor]) state_n = SELECT;
        else if (target_ready)      state_n = BUSY;
        else                        valid_n = 1'b1;
      end
      BUSY: begin
        if (at_floor && (cur_floor == target_floor)) begin
          state_n = SELECT;
        end
`ifdef SCHED_PREEMPT_EN
        else if (has_between) begin
          state_n = OFFER;
          valid_n = 1'b1;
          tgt_n   = between;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (N_FLOORS=4, DEB_CYCLES=4).
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_call;
  logic [1:0] cur_floor;
  logic       at_floor;
  logic       target_ready;
  logic       target_valid;
  logic [1:0] target_floor;
  logic       dir_up;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  elevator_call_scheduler #(
    .N_FLOORS   (4),
    .FLOOR_W    (2),
    .DEB_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_call     (btn_call),
    .cur_floor    (cur_floor),
    .at_floor     (at_floor),
    .target_ready (target_ready),
    .target_valid (target_valid),
    .target_floor (target_floor),
    .dir_up       (dir_up),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    rst = 1'b1; btn_call = '0; cur_floor = 2'd0; at_floor = 1'b0; target_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_valid", 32'(target_valid), 32'h0);
    chk("rst_dir", 32'(dir_up), 32'h1);
    chk("rst_target", 32'(target_floor), 32'h0);
    tick(2);
    chk("idle_pending", 32'(pending), 32'h0);
    chk("idle_valid", 32'(target_valid), 32'h0);

    // Press floor 2 from floor 0: pending after 7 cycles, offer 2 cycles later
    btn_call = 4'b0100;
    tick(6);
    chk("press_not_yet", 32'(pending), 32'h0);
    tick(1);
    chk("press_pending", 32'(pending), 32'h4);
    tick(1);
    chk("select_valid", 32'(target_valid), 32'h0);
    tick(1);
    chk("offer_valid", 32'(target_valid), 32'h1);
    chk("offer_target", 32'(target_floor), 32'h2);

    // Offer held while ready is low
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (i == 0) btn_call = 4'b0000;
      chk("hold_valid", 32'(target_valid), 32'h1);
      chk("hold_target", 32'(target_floor), 32'h2);
    end
    target_ready = 1'b1;
    tick(1);
    target_ready = 1'b0;
    chk("accept_valid_drop", 32'(target_valid), 32'h0);
    chk("busy_pending", 32'(pending), 32'h4);
    cur_floor = 2'd2; at_floor = 1'b1;
    tick(1);
    at_floor = 1'b0;
    chk("arrive_clear", 32'(pending), 32'h0);
    tick(2);
    chk("back_idle_valid", 32'(target_valid), 32'h0);

    // Same-floor clash: clear and new edge meet on floor 2
    btn_call = 4'b0100;
    tick(6);
    at_floor = 1'b1;
    tick(1);
    at_floor = 1'b0;
    chk("clash_pending", 32'(pending), 32'h0);
    tick(3);
    chk("held_no_reset", 32'(pending), 32'h0);
    btn_call = 4'b0000;
    tick(8);

    // Bounce on floor 1 every 2 cycles never latches
    for (int i = 0; i < 10; i++) begin
      btn_call[1] = ~btn_call[1];
      tick(2);
      chk("bounce_pending", 32'(pending), 32'h0);
    end
    btn_call = 4'b0000;
    tick(8);
    chk("bounce_settled", 32'(pending), 32'h0);

    // SCAN: car at 1 going up with calls at 0 and 3
    chk("scan_dir_start", 32'(dir_up), 32'h1);
    cur_floor = 2'd1;
    btn_call = 4'b1001;
    tick(7);
    chk("scan_pending", 32'(pending), 32'h9);
    tick(2);
    chk("scan_first_valid", 32'(target_valid), 32'h1);
    chk("scan_first_target", 32'(target_floor), 32'h3);
    chk("scan_first_dir", 32'(dir_up), 32'h1);
    btn_call = 4'b0000;
    target_ready = 1'b1;
    tick(1);
    target_ready = 1'b0;
    chk("scan_busy_valid", 32'(target_valid), 32'h0);
    cur_floor = 2'd2; at_floor = 1'b1;
    tick(1);
    chk("pass_floor2_valid", 32'(target_valid), 32'h0);
    chk("pass_floor2_pending", 32'(pending), 32'h9);
    cur_floor = 2'd3;
    tick(1);
    at_floor = 1'b0;
    chk("arrive3_pending", 32'(pending), 32'h1);
    tick(1);
    chk("scan_second_valid", 32'(target_valid), 32'h1);
    chk("scan_second_target", 32'(target_floor), 32'h0);
    chk("scan_top_dir", 32'(dir_up), 32'h0);

    // Car stops at the offered floor before accepting: offer is withdrawn
    cur_floor = 2'd0; at_floor = 1'b1;
    tick(1);
    at_floor = 1'b0;
    chk("withdraw_pending", 32'(pending), 32'h0);
    chk("withdraw_still_valid", 32'(target_valid), 32'h1);
    tick(1);
    chk("withdraw_valid", 32'(target_valid), 32'h0);
    tick(1);
    chk("bottom_dir", 32'(dir_up), 32'h1);
    chk("withdraw_idle_valid", 32'(target_valid), 32'h0);

    // Ready held high: single-cycle offer, then BUSY toward floor 3
    cur_floor = 2'd1;
    target_ready = 1'b1;
    btn_call = 4'b1000;
    tick(7);
    chk("ready_hi_pending", 32'(pending), 32'h8);
    tick(2);
    chk("ready_hi_valid", 32'(target_valid), 32'h1);
    chk("ready_hi_target", 32'(target_floor), 32'h3);
    tick(1);
    chk("ready_hi_one_cycle", 32'(target_valid), 32'h0);
    target_ready = 1'b0;

    // New call at 2 while travelling 1 -> 3
    btn_call = 4'b0100;
    tick(7);
    chk("preempt_pending", 32'(pending), 32'hC);
    tick(1);
`ifdef SCHED_PREEMPT_EN
    chk("preempt_valid", 32'(target_valid), 32'h1);
    chk("preempt_target", 32'(target_floor), 32'h2);
`else
    chk("no_preempt_valid", 32'(target_valid), 32'h0);
    chk("no_preempt_target", 32'(target_floor), 32'h3);
`endif
    chk("preempt_keep3", 32'(pending), 32'hC);

    // Reset mid-operation drops everything
    btn_call = 4'b0000;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_pending", 32'(pending), 32'h0);
    chk("midrst_valid", 32'(target_valid), 32'h0);
    chk("midrst_dir", 32'(dir_up), 32'h1);
    chk("midrst_target", 32'(target_floor), 32'h0);
    tick(10);
    chk("post_rst_pending", 32'(pending), 32'h0);
    chk("post_rst_valid", 32'(target_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
